wgt_fifo_ctrl: RTL

Sequencer for the 16-lane weight FIFO array feeding the systolic array. It clears the FIFOs and loads one weight tile from the DMA stream (one beat = one 16-bit word per lane). It then replays the tile `num_pass` times with diagonally staggered per-lane read enables, and rewinds the read pointers between passes. It also drives the lane-count select that zero-masks unused filter lanes on write.

---
 rtl/wgt_fifo_if.sv | 38 +++
 rtl/wgt_fifo_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/wgt_fifo_if.sv
// Weight FIFO sequencer bus: tile configuration, DMA load handshake and the
// control strobes that go to the 16-lane weight FIFO array.
//   master : host/DMA/array side (drives start, config, load_valid, compute_go)
//   slave  : wgt_fifo_ctrl (drives FIFO strobes, status pulses, busy)
interface wgt_fifo_if #(
  parameter int NUM_FIFO = 16,
  parameter int LEN_W    = 13,
  parameter int PASS_W   = 8
);
  logic                start;
  logic [4:0]          num_filter;
  logic [LEN_W-1:0]    wgt_len;
  logic [PASS_W-1:0]   num_pass;
  logic                load_valid;
  logic                load_ready;
  logic                compute_go;
  logic                wr_en;
  logic [NUM_FIFO-1:0] rd_en;
  logic                rd_clr;
  logic                wr_clr;
  logic [4:0]          read_wgt_size;
  logic                load_done;
  logic                pass_done;
  logic                done;
  logic                busy;

  modport master (
    output start, num_filter, wgt_len, num_pass, load_valid, compute_go,
    input  load_ready, wr_en, rd_en, rd_clr, wr_clr, read_wgt_size,
           load_done, pass_done, done, busy
  );

  modport slave (
    input  start, num_filter, wgt_len, num_pass, load_valid, compute_go,
    output load_ready, wr_en, rd_en, rd_clr, wr_clr, read_wgt_size,
           load_done, pass_done, done, busy
  );
endinterface

// File: rtl/wgt_fifo_ctrl.sv
// Weight FIFO sequencer. Clears the FIFO array, loads one weight tile from the
// DMA stream, then replays it num_pass times with diagonally staggered per-lane
// read enables, rewinding the read pointers between passes.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - wgt_fifo_if.slave: start/config, load_valid/load_ready, compute_go,
//          wr_en, rd_en[NUM_FIFO], rd_clr, wr_clr, read_wgt_size, load_done,
//          pass_done, done, busy
module wgt_fifo_ctrl #(
  parameter int NUM_FIFO          = 16,
  parameter int MAX_WGT_FIFO_SIZE = 4608,
  parameter int LEN_W             = 13,
  parameter int PASS_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  wgt_fifo_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_WAIT_GO, S_READ, S_RCLR, S_DONE
  } state_t;

  state_t              state, state_d;
  // One counter serves as the beat counter in LOAD and as rd_cnt in READ;
  // the two phases never overlap.
  logic [LEN_W-1:0]    cnt;
  logic [PASS_W-1:0]   pass_idx;
  logic [4:0]          nf_q;
  logic [LEN_W-1:0]    len_q;
  logic [PASS_W-1:0]   np_q;
  logic                load_done_q;
  logic [NUM_FIFO-1:0] rd_en_d;

  // Sanitised configuration, applied only when a start is accepted.
  logic              start_ok;
  logic [4:0]        nf_sat;
  logic [LEN_W-1:0]  len_sat;
  logic [PASS_W-1:0] np_sat;

  assign start_ok = (state == S_IDLE) && bus.start && (bus.wgt_len != '0);
  assign nf_sat   = (bus.num_filter == 5'd0 || bus.num_filter > 5'(NUM_FIFO))
                    ? 5'(NUM_FIFO) : bus.num_filter;
  assign len_sat  = (bus.wgt_len > LEN_W'(MAX_WGT_FIFO_SIZE))
                    ? LEN_W'(MAX_WGT_FIFO_SIZE) : bus.wgt_len;
  assign np_sat   = (bus.num_pass == '0) ? PASS_W'(1) : bus.num_pass;

  logic             last_beat;
  logic [LEN_W-1:0] pass_last;
  logic             last_pass;

  assign last_beat = bus.load_valid && (cnt == len_q - LEN_W'(1));
  // A pass spans wgt_len + num_filter - 1 cycles: the last lane starts
  // num_filter-1 cycles after lane 0 and then streams wgt_len words.
  assign pass_last = len_q + LEN_W'(nf_q) - LEN_W'(2);
  assign last_pass = (pass_idx == np_q - PASS_W'(1));

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:    if (start_ok) state_d = S_CLR;
      S_CLR:     state_d = S_LOAD;
      S_LOAD:    if (last_beat) state_d = S_WAIT_GO;
      S_WAIT_GO: if (bus.compute_go) state_d = S_READ;
      S_READ:    if (cnt == pass_last) state_d = last_pass ? S_DONE : S_RCLR;
      S_RCLR:    state_d = S_WAIT_GO;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pass_idx    <= '0;
      nf_q        <= 5'(NUM_FIFO);
      len_q       <= '0;
      np_q        <= '0;
      load_done_q <= 1'b0;
    end else begin
      state       <= state_d;
      load_done_q <= (state == S_LOAD) && last_beat;
      if (start_ok) begin
        nf_q     <= nf_sat;
        len_q    <= len_sat;
        np_q     <= np_sat;
        cnt      <= '0;
        pass_idx <= '0;
      end
      case (state)
        S_LOAD:    if (bus.load_valid) cnt <= last_beat ? '0 : cnt + LEN_W'(1);
        S_WAIT_GO: cnt <= '0;
        S_READ:    cnt <= cnt + LEN_W'(1);
        S_RCLR:    pass_idx <= pass_idx + PASS_W'(1);
        default:   ;
      endcase
    end
  end

  // Diagonal stagger: lane i reads words 0..wgt_len-1 during rd_cnt i..i+wgt_len-1.
  always_comb begin
    rd_en_d = '0;
    if (state == S_READ) begin
      for (int i = 0; i < NUM_FIFO; i++) begin
        rd_en_d[i] = (5'(i) < nf_q) && (cnt >= LEN_W'(i)) &&
                     ({1'b0, cnt} < {1'b0, len_q} + (LEN_W+1)'(i));
      end
    end
  end

  assign bus.load_ready    = (state == S_LOAD);
  assign bus.wr_en         = (state == S_LOAD) && bus.load_valid;
  assign bus.rd_en         = rd_en_d;
  assign bus.wr_clr        = (state == S_CLR);
  assign bus.rd_clr        = (state == S_CLR) || (state == S_RCLR);
  assign bus.read_wgt_size = nf_q;
  assign bus.load_done     = load_done_q;
  assign bus.pass_done     = (state == S_RCLR) || (state == S_DONE);
  assign bus.done          = (state == S_DONE);
  assign bus.busy          = (state != S_IDLE);

endmodule
